pong_frame_ctrl: RTL and testbench

//  Per-frame game-state sequencer for the VGA pong display. On each frame_pulse (start of

---
 rtl/pong_pkg.sv | 37 +++
 rtl/pong_paddle_step.sv | 21 ++
 rtl/pong_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pong_frame_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong geometry, FSM state encoding and direction type.
// The pixel generator imports the same geometry so sprite origins line up with game state.
package pong_pkg;

    localparam int SCR_W     = 640;
    localparam int SCR_H     = 480;
    localparam int PAD_W     = 10;
    localparam int PAD_H     = 128;
    localparam int P1_X      = 23;
    localparam int P2_X      = 607;
    localparam int PAD_STEP  = 4;
    localparam int BALL_SZ   = 8;
    localparam int BALL_STEP = 2;

    localparam logic [9:0] PAD_Y_MAX  = 10'(SCR_H - PAD_H);
    localparam logic [9:0] PAD_Y_RST  = 10'((SCR_H - PAD_H) / 2);
    localparam logic [9:0] BALL_X_RST = 10'((SCR_W - BALL_SZ) / 2);
    localparam logic [9:0] BALL_Y_RST = 10'((SCR_H - BALL_SZ) / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PADDLE,
        ST_BALL,
        ST_HIT,
        ST_COMMIT
    } state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle_step.sv
// Next paddle top y from current y and up/down buttons, clamped to the screen.
// Purely combinational; opposing or idle buttons hold the paddle.
module pong_paddle_step
    import pong_pkg::*;
(
    input  logic [9:0] y_i,
    input  logic       up_i,
    input  logic       dn_i,
    output logic [9:0] y_o
);

    always_comb begin
        y_o = y_i;
        if (up_i && !dn_i) begin
            y_o = (y_i >= 10'(PAD_STEP)) ? y_i - 10'(PAD_STEP) : 10'd0;
        end else if (dn_i && !up_i) begin
            y_o = (y_i >= PAD_Y_MAX - 10'(PAD_STEP)) ? PAD_Y_MAX : y_i + 10'(PAD_STEP);
        end
    end

endmodule

// File: rtl/pong_frame_ctrl.sv
// Per-frame pong sequencer: paddles, ball, collisions and scoring, then one atomic commit.
// Four cycles from an accepted frame_pulse to upd_done; pulses arriving while busy are dropped.
module pong_frame_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_pulse,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic       serve,
    output logic [9:0] p1_y,
    output logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       busy,
    output logic       upd_done
);

    localparam logic signed [11:0] S_STEP    = 12'(BALL_STEP);
    localparam logic signed [11:0] S_BALL_SZ = 12'(BALL_SZ);
    localparam logic signed [11:0] S_PAD_H   = 12'(PAD_H);
    localparam logic signed [11:0] S_P1_X    = 12'(P1_X);
    localparam logic signed [11:0] S_P1_EDGE = 12'(P1_X + PAD_W);
    localparam logic signed [11:0] S_P2_X    = 12'(P2_X);
    localparam logic signed [11:0] S_P2_EDGE = 12'(P2_X + PAD_W);
    localparam logic signed [11:0] S_P2_SNAP = 12'(P2_X - BALL_SZ);
    localparam logic signed [11:0] S_X_MISS  = 12'(SCR_W - BALL_SZ);
    localparam logic signed [11:0] S_Y_MAX   = 12'(SCR_H - BALL_SZ);
    localparam logic signed [11:0] S_X_RST   = 12'(BALL_X_RST);
    localparam logic signed [11:0] S_Y_RST   = 12'(BALL_Y_RST);

    state_t             state_q, state_d;
    logic [9:0]         p1_q, p1_d, p2_q, p2_d, p1_nxt, p2_nxt;
    logic signed [11:0] bx_q, bx_d, by_q, by_d;
    logic signed [11:0] nx, ny, p1_s, p2_s;
    logic [3:0]         sc1_q, sc1_d, sc2_q, sc2_d;
    logic               serving_q, serving_d;
    dir_t               dx_q, dx_d, dy_q, dy_d;
    logic               ov1, ov2;

    logic [9:0]         p1_y_q, p2_y_q, ball_x_q, ball_y_q;
    logic [3:0]         score_p1_q, score_p2_q;

    pong_paddle_step u_step_p1 (.y_i(p1_q), .up_i(p1_up), .dn_i(p1_dn), .y_o(p1_nxt));
    pong_paddle_step u_step_p2 (.y_i(p2_q), .up_i(p2_up), .dn_i(p2_dn), .y_o(p2_nxt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_pulse) state_d = ST_PADDLE;
            ST_PADDLE: state_d = ST_BALL;
            ST_BALL:   state_d = ST_HIT;
            ST_HIT:    state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        upd_done = (state_q == ST_COMMIT);
    end

    // HIT sees the paddle positions written in PADDLE and the ball position written in BALL.
    assign p1_s = signed'({2'b00, p1_q});
    assign p2_s = signed'({2'b00, p2_q});
    assign ov1  = (by_q + S_BALL_SZ > p1_s) && (by_q < p1_s + S_PAD_H);
    assign ov2  = (by_q + S_BALL_SZ > p2_s) && (by_q < p2_s + S_PAD_H);
    assign nx   = bx_q + ((dx_q == DIR_NEG) ? -S_STEP : S_STEP);
    assign ny   = by_q + ((dy_q == DIR_NEG) ? -S_STEP : S_STEP);

    always_comb begin
        p1_d      = p1_q;
        p2_d      = p2_q;
        bx_d      = bx_q;
        by_d      = by_q;
        sc1_d     = sc1_q;
        sc2_d     = sc2_q;
        serving_d = serving_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        case (state_q)
            ST_PADDLE: begin
                p1_d = p1_nxt;
                p2_d = p2_nxt;
            end
            ST_BALL: begin
                if (serving_q) begin
                    if (serve) serving_d = 1'b0;
                end else begin
                    bx_d = nx;
                    by_d = ny;
                    // Landing exactly on a wall counts as touching it, so the bounce starts there.
                    if (ny <= 12'sd0) begin
                        by_d = 12'sd0;
                        dy_d = DIR_POS;
                    end else if (ny >= S_Y_MAX) begin
                        by_d = S_Y_MAX;
                        dy_d = DIR_NEG;
                    end
                end
            end
            ST_HIT: begin
                if (dx_q == DIR_NEG) begin
                    if (bx_q <= S_P1_EDGE && bx_q + S_BALL_SZ > S_P1_X && ov1) begin
                        bx_d = S_P1_EDGE;
                        dx_d = DIR_POS;
                    end else if (bx_q <= 12'sd0) begin
                        sc2_d     = sat_inc4(sc2_q);
                        bx_d      = S_X_RST;
                        by_d      = S_Y_RST;
                        serving_d = 1'b1;
                        dx_d      = DIR_POS;
                    end
                end else begin
                    if (bx_q + S_BALL_SZ >= S_P2_X && bx_q < S_P2_EDGE && ov2) begin
                        bx_d = S_P2_SNAP;
                        dx_d = DIR_NEG;
                    end else if (bx_q >= S_X_MISS) begin
                        sc1_d     = sat_inc4(sc1_q);
                        bx_d      = S_X_RST;
                        by_d      = S_Y_RST;
                        serving_d = 1'b1;
                        dx_d      = DIR_NEG;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_q      <= PAD_Y_RST;
            p2_q      <= PAD_Y_RST;
            bx_q      <= S_X_RST;
            by_q      <= S_Y_RST;
            sc1_q     <= 4'd0;
            sc2_q     <= 4'd0;
            serving_q <= 1'b1;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_POS;
        end else begin
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            sc1_q     <= sc1_d;
            sc2_q     <= sc2_d;
            serving_q <= serving_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    // Sprite origins move only here, inside vblank, so active video never sees a torn update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_y_q     <= PAD_Y_RST;
            p2_y_q     <= PAD_Y_RST;
            ball_x_q   <= BALL_X_RST;
            ball_y_q   <= BALL_Y_RST;
            score_p1_q <= 4'd0;
            score_p2_q <= 4'd0;
        end else if (state_q == ST_COMMIT) begin
            p1_y_q     <= p1_q;
            p2_y_q     <= p2_q;
            ball_x_q   <= bx_q[9:0];
            ball_y_q   <= by_q[9:0];
            score_p1_q <= sc1_q;
            score_p2_q <= sc2_q;
        end
    end

    assign p1_y     = p1_y_q;
    assign p2_y     = p2_y_q;
    assign ball_x   = ball_x_q;
    assign ball_y   = ball_y_q;
    assign score_p1 = score_p1_q;
    assign score_p2 = score_p2_q;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Directed bench for pong_frame_ctrl: walks one long hand-traced rally through bounces, hits and misses.
module tb_pong_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_pulse = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0, serve = 1'b0;
    logic [9:0] p1_y, p2_y, ball_x, ball_y;
    logic [3:0] score_p1, score_p2;
    logic       busy, upd_done;

    int errors = 0;
    int checks = 0;

    pong_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_pulse(frame_pulse),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .serve      (serve),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .busy       (busy),
        .upd_done   (upd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int ex, input int ey);
        chk({tag, "_x"}, 32'(ball_x), 32'(ex));
        chk({tag, "_y"}, 32'(ball_y), 32'(ey));
    endtask

    // One frame: drive buttons, pulse, check latency and busy length; optionally check
    // that ball outputs still hold the previous frame's values during the COMMIT cycle.
    task automatic frame(input logic u1, input logic d1, input logic u2, input logic d2,
                         input logic sv, input logic hold, input int hx, input int hy);
        int n;
        int bc;
        @(negedge clk);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; serve = sv;
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        n  = 1;
        bc = int'(busy);
        while (!upd_done && n < 10) begin
            @(negedge clk);
            n++;
            bc += int'(busy);
        end
        chk("latency", 32'(n), 32'd4);
        chk("busy_cycles", 32'(bc), 32'd4);
        if (hold) chk_ball("hold_in_commit", hx, hy);
        @(negedge clk);
        chk("idle_after", {30'd0, busy, upd_done}, 32'd0);
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0; serve = 1'b0;
    endtask

    task automatic run(input int cnt, input logic u1, input logic d1,
                       input logic u2, input logic d2, input logic sv);
        for (int i = 0; i < cnt; i++) frame(u1, d1, u2, d2, sv, 1'b0, 0, 0);
    endtask

    initial begin
        int dn_cnt;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_p1", 32'(p1_y), 32'd176);
        chk("rst_p2", 32'(p2_y), 32'd176);
        chk_ball("rst_ball", 316, 236);
        chk("rst_scores", {24'd0, score_p1, score_p2}, 32'd0);
        chk("rst_flags", {30'd0, busy, upd_done}, 32'd0);

        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("idle_p1", 32'(p1_y), 32'd176);
        chk_ball("idle_ball", 316, 236);

        // Second pulse lands in BALL and must be dropped.
        @(negedge clk);
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        @(negedge clk);
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        dn_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            dn_cnt += int'(upd_done);
            @(negedge clk);
        end
        chk("double_pulse_done", 32'(dn_cnt), 32'd1);

        for (int i = 1; i <= 50; i++) begin
            frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            if (i == 43) chk("p1_up_43", 32'(p1_y), 32'd4);
            if (i == 44) chk("p1_up_44", 32'(p1_y), 32'd0);
        end
        chk("p1_up_50", 32'(p1_y), 32'd0);

        for (int i = 1; i <= 50; i++) begin
            frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            if (i == 43) chk("p2_dn_43", 32'(p2_y), 32'd348);
            if (i == 44) chk("p2_dn_44", 32'(p2_y), 32'd352);
        end
        chk("p2_dn_50", 32'(p2_y), 32'd352);

        frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("both_p1", 32'(p1_y), 32'd0);
        chk("both_p2", 32'(p2_y), 32'd352);
        chk_ball("still_serving", 316, 236);

        // Serve, then the ball heads right and down.
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk_ball("serve_frame", 316, 236);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 316, 236);
        chk_ball("move_1", 318, 238);
        run(9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("move_10", 336, 256);
        run(107, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("move_117", 550, 470);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("bottom_wall", 552, 472);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("after_bottom", 554, 470);
        run(23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("p2_hit", 599, 424);

        // Back toward the left paddle, which moves down to 40 to meet it.
        run(10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("p1_at_40", 32'(p1_y), 32'd40);
        chk_ball("left_10", 579, 404);
        run(201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("near_top", 177, 2);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("top_wall", 175, 0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("after_top", 173, 2);
        run(69, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("before_p1", 35, 140);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("p1_hit", 33, 142);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("p1_rebound", 35, 144);

        // Rightward pass misses the right paddle at 352.
        run(298, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("before_p2_miss", 631, 204);
        chk("score_p1_before", 32'(score_p1), 32'd0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("score_p1_after", 32'(score_p1), 32'd1);
        chk_ball("p1_point_centre", 316, 236);

        // Serve leftward with the left paddle parked at 176: the ball passes under it.
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("p1_at_44", 32'(p1_y), 32'd44);
        chk_ball("serve2_frame", 316, 236);
        run(33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("p1_at_176", 32'(p1_y), 32'd176);
        chk_ball("left2_33", 250, 170);
        run(124, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ball("before_p1_miss", 2, 78);
        chk("score_p2_before", 32'(score_p2), 32'd0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("score_p2_after", 32'(score_p2), 32'd1);
        chk("score_p1_kept", 32'(score_p1), 32'd1);
        chk_ball("p2_point_centre", 316, 236);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("serving_again", 316, 236);

        // Reset while the FSM sits in BALL: abort without commit.
        @(negedge clk);
        p2_up = 1'b1;
        frame_pulse = 1'b1;
        @(negedge clk);
        frame_pulse = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_p2", 32'(p2_y), 32'd176);
        chk("midrst_scores", {24'd0, score_p1, score_p2}, 32'd0);
        chk("midrst_flags", {30'd0, busy, upd_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        p2_up = 1'b0;
        dn_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dn_cnt += int'(upd_done);
        end
        chk("midrst_no_done", 32'(dn_cnt), 32'd0);
        chk("midrst_p2_hold", 32'(p2_y), 32'd176);

        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk_ball("post_rst_move", 318, 238);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
